// File: rtl/lab01_pkg.sv
// Shared types and constants for the lab01 truth-table checker.
package lab01_pkg;

   localparam int unsigned VEC_W    = 4;
   localparam logic [15:0] LAB01_TT = 16'h0007;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StSample,
      StDone
   } state_e;

endpackage

// File: rtl/lab01_settle_timer.sv
// Settle timer: loads SETTLE, counts down while enabled, pulses expire on the last wait cycle.
module lab01_settle_timer
   import lab01_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);

   logic [VEC_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= VEC_W'(SETTLE);
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - VEC_W'(1);
      end
   end

   // A load of N gives exactly N enabled cycles, the Nth one flagged.
   assign expire = en && (count_q == VEC_W'(1));

endmodule

// File: rtl/lab01_checker.sv
// Sweeps all 16 {a,b,c,d} vectors, samples y_in after a settle delay and compares to EXPECTED.
module lab01_checker
   import lab01_pkg::*;
#(
   parameter int unsigned SETTLE   = 2,
   parameter logic [15:0] EXPECTED = LAB01_TT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        y_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  err_count,
   output logic [15:0] table_out
);

   state_e           state_q, state_d;
   logic [VEC_W-1:0] index_q;
   logic [15:0]      table_q;
   logic [4:0]       err_q;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   logic clear, sample, last_vec, timer_load, timer_en, expire;

   assign last_vec = (index_q == VEC_W'(15));

   lab01_settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .en     (timer_en),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StSettle;
         StSettle: if (expire) state_d = StSample;
         StSample: state_d = last_vec ? StDone : StSettle;
         StDone:   if (start) state_d = StSettle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      clear      = start && ((state_q == StIdle) || (state_q == StDone));
      sample     = (state_q == StSample);
      timer_en   = (state_q == StSettle);
      timer_load = clear || (sample && !last_vec);
      busy_d     = clear || (state_q == StSettle) || (state_q == StSample);
      // Flags lag the state by one cycle, so done lands one cycle after the last sample.
      done_d     = (state_q == StDone) && !clear;
      pass_d     = done_d && (err_q == 5'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         index_q <= '0;
         table_q <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         pass_q <= pass_d;
         if (clear) begin
            index_q <= '0;
            table_q <= '0;
            err_q   <= '0;
         end else if (sample) begin
            table_q[index_q] <= y_in;
            if (y_in != EXPECTED[index_q]) begin
               err_q <= err_q + 5'd1;
            end
            if (!last_vec) begin
               index_q <= index_q + VEC_W'(1);
            end
         end
      end
   end

   assign {a, b, c, d} = index_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign table_out    = table_q;

endmodule

// File: tb/tb_lab01_checker.sv
// Randomized self-checking bench for lab01_checker against a truth-table reference model.
module tb_lab01_checker;

   localparam int          S    = 2;
   localparam int          LAT  = 16 * (S + 1) + 1;
   localparam logic [15:0] GOLD = 16'h0007;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        a, b, c, d;
   logic        y_in;
   logic        busy, done, pass;
   logic [4:0]  err_count;
   logic [15:0] table_out;

   int          total = 0;
   int          bad = 0;
   int          mode = 0;
   logic [15:0] rand_tt = 16'h0000;

   always #5 clk = ~clk;

   lab01_checker #(
      .SETTLE   (S),
      .EXPECTED (GOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .y_in      (y_in),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .table_out (table_out)
   );

   // Device under check: 0 good gate, 1 stuck-0, 2 stuck-1, 3 arbitrary table.
   function automatic logic ref_y(input int m, input logic [3:0] v, input logic [15:0] rt);
      case (m)
         0:       return !(v[3] | v[2]) && !(v[1] & v[0]);
         1:       return 1'b0;
         2:       return 1'b1;
         default: return rt[v];
      endcase
   endfunction

   function automatic logic [15:0] ref_table(input int m, input logic [15:0] rt);
      logic [15:0] t;
      for (int i = 0; i < 16; i++) t[i] = ref_y(m, 4'(i), rt);
      return t;
   endfunction

   function automatic int ref_errs(input logic [15:0] tt);
      int n = 0;
      for (int i = 0; i < 16; i++) if (tt[i] != GOLD[i]) n++;
      return n;
   endfunction

   always_comb y_in = ref_y(mode, {a, b, c, d}, rand_tt);

   // Pulses start, then tracks the sweep cycle by cycle until done or the budget runs out.
   task automatic sweep(input bit inject, output int lat, output int map_bad, output logic d0);
      int exp_idx;
      lat     = -1;
      map_bad = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      d0 = done;
      for (int t = 0; t <= LAT + 20; t++) begin
         if (t > 0) begin
            if (inject && t == 4 * (S + 1) + 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         exp_idx = t / (S + 1);
         if (exp_idx > 15) exp_idx = 15;
         if ({a, b, c, d} !== 4'(exp_idx)) map_bad++;
         if (busy !== (t < LAT)) map_bad++;
         if (!done && pass !== 1'b0) map_bad++;
         if (done === 1'b1) begin
            lat = t;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({a, b, c, d, busy, done, pass, err_count, table_out} !== 28'd0) begin
         bad++;
         $display("FAIL reset_state: got %h want 0",
                  {a, b, c, d, busy, done, pass, err_count, table_out});
      end
      rst = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_start_ignored: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_sweep(input int m, input bit inject, input string name);
      logic [15:0] et;
      int          ee, lat, mb;
      logic        d0;
      mode = m;
      et = ref_table(m, rand_tt);
      ee = ref_errs(et);
      sweep(inject, lat, mb, d0);
      total++;
      if (d0 !== 1'b0) begin
         bad++;
         $display("FAIL %s_done_drop: got %b want 0", name, d0);
      end
      total++;
      if (lat != LAT) begin
         bad++;
         $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
      end
      total++;
      if (mb != 0) begin
         bad++;
         $display("FAIL %s_mapping: got %0d bad cycles want 0", name, mb);
      end
      total++;
      if (table_out !== et) begin
         bad++;
         $display("FAIL %s_table: got %h want %h", name, table_out, et);
      end
      total++;
      if (err_count !== 5'(ee)) begin
         bad++;
         $display("FAIL %s_err_count: got %0d want %0d", name, err_count, ee);
      end
      total++;
      if (pass !== (ee == 0)) begin
         bad++;
         $display("FAIL %s_pass: got %b want %b", name, pass, (ee == 0));
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || table_out !== et || err_count !== 5'(ee)) begin
         bad++;
         $display("FAIL %s_hold: done=%b busy=%b table=%h errs=%0d want 1 0 %h %0d",
                  name, done, busy, table_out, err_count, et, ee);
      end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      mode = 2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while ({a, b, c, d} !== 4'd7 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n >= 200 || busy !== 1'b1 || err_count !== 5'd4) begin
         bad++;
         $display("FAIL midreset_reach_idx7: cycles=%0d busy=%b errs=%0d want <200 1 4",
                  n, busy, err_count);
      end
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      total++;
      if ({a, b, c, d, busy, done, pass, err_count, table_out} !== 28'd0) begin
         bad++;
         $display("FAIL midreset_zero: got %h want 0",
                  {a, b, c, d, busy, done, pass, err_count, table_out});
      end
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || {a, b, c, d} !== 4'd0) begin
         bad++;
         $display("FAIL midreset_stays_idle: busy=%b vec=%0d want 0 0", busy, {a, b, c, d});
      end
      test_sweep(0, 1'b0, "after_reset");
   endtask

   initial begin
      test_reset();
      test_sweep(0, 1'b0, "good");
      test_sweep(1, 1'b0, "stuck0");
      test_sweep(2, 1'b0, "stuck1");
      test_sweep(0, 1'b1, "start_busy");
      for (int k = 0; k < 4; k++) begin
         rand_tt = 16'($urandom);
         test_sweep(3, 1'b0, "random");
      end
      rand_tt = ~GOLD;
      test_sweep(3, 1'b0, "all_bad");
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lab01_checker.md
LAB01_CHECKER -- requirements
Module: lab01_checker

Interface
REQ-001 Parameter: SETTLE, default 2, number of wait cycles after each vector is applied before y_in is sampled; legal range 1..15.
REQ-002 Parameter: EXPECTED, default 16'h0007, golden truth table; bit i is the required Y for input vector i = {A,B,C,D}.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to begin a 16-vector sweep.
REQ-006 Port: a  output  1  stimulus bit 3 of current vector.
REQ-007 Port: b  output  1  stimulus bit 2 of current vector.
REQ-008 Port: c  output  1  stimulus bit 1 of current vector.
REQ-009 Port: d  output  1  stimulus bit 0 of current vector.
REQ-010 Port: y_in  input  1  response from the device under check.
REQ-011 Port: busy  output  1  high while a sweep is in progress.
REQ-012 Port: done  output  1  high, held, once a sweep completes, until the next start or reset.
REQ-013 Port: pass  output  1  valid when done=1; high when err_count = 0.
REQ-014 Port: err_count  output  5  number of mismatching vectors in the current/last sweep, 0..16.
REQ-015 Port: table_out  output  16  captured truth table; bit i = y_in sampled for vector i.

Function
REQ-016 FSM states: IDLE, SETTLE, SAMPLE, DONE; encoding free.
REQ-017 IDLE: start=1 -> SETTLE; vector index clears to 0; table_out and err_count clear to 0; busy=1 from next cycle.
REQ-018 {a,b,c,d} SHALL equal the 4-bit vector index at all times (index 8 -> a=1,b=0,c=0,d=0); registered outputs.
REQ-019 SETTLE: 4-bit timer counts SETTLE cycles, then -> SAMPLE.
REQ-020 SAMPLE (one cycle): table_out[index] <= y_in; if y_in != EXPECTED[index], err_count increments by 1.
REQ-021 SAMPLE with index < 15 -> index+1, timer reloads, -> SETTLE; index = 15 -> DONE, no index wrap.
REQ-022 Per-vector cost SETTLE+1 cycles; done rises exactly 16*(SETTLE+1)+1 cycles after the cycle start is sampled in IDLE.
REQ-023 DONE: busy=0, done=1, pass = (err_count == 0); outputs hold; start=1 -> same action as REQ-017 (restart), done drops next cycle.
REQ-024 start while busy=1 SHALL be ignored; no restart, no error.
REQ-025 err_count SHALL saturate-free reach 16 (all mismatch) without overflow; width 5 guarantees this.
REQ-026 pass SHALL be 0 whenever done=0.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, index 0, {a,b,c,d}=0, busy=0, done=0, pass=0, err_count=0, table_out=0, timer=0 on the next cycle.
REQ-028 rst SHALL take priority over start and over any in-flight sweep (mid-sweep reset aborts, no partial result retained).
REQ-029 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-030 Shared package lab01_pkg SHALL hold the FSM state type, VEC_W = 4, and LAB01_TT = 16'h0007 (default for EXPECTED).
REQ-031 One sub-module: lab01_settle_timer (load, count down, expire pulse); everything else in lab01_checker.

Verification
REQ-032 Good DUT (NOR(A,B) AND NAND(C,D) on y_in), SETTLE=2, start pulse -> done after 49 cycles, table_out=16'h0007, err_count=0, pass=1.
REQ-033 y_in tied 0 -> table_out=16'h0000, err_count=3, pass=0; y_in tied 1 -> table_out=16'hFFFF, err_count=13, pass=0.
REQ-034 Stimulus mapping: monitor {a,b,c,d} across sweep -> values 0,1,...,15 in order, each held SETTLE+1 cycles.
REQ-035 rst asserted while index=7 -> all outputs zero next cycle; fresh start then completes normally with table_out=16'h0007.
REQ-036 start pulsed at index 4 mid-sweep -> ignored, done timing unchanged; start in DONE -> done=0 next cycle, sweep reruns.
